perf_stats_unit: RTL and testbench
==================================

// Module: perf_stats_unit
// PURPOSE
//  Parametrised end-of-run statistics block for the CPU test harness. It counts
//  elapsed cycles and NUM_EVENTS event channels; channel 0 is retired instructions.
//  On a stat_control rising edge it snapshots every counter. It then computes IPC as
//  an unsigned fixed-point quotient with a multi-cycle divider and pulses stat_valid.
//  Sits beside the core; the top-level bench reads the snapshot ports.
// PARAMETERS
//  NUM_EVENTS  4   number of event channels (>=1); channel 0 = instructions retired
//  CNT_W       32  width of each counter and of the cycle counter
//  FRAC_W      8   fractional bits of the IPC result
// PORTS
//  clk           in   1                     clock, rising edge
//  rst           in   1                     asynchronous, active-high reset
//  count_en      in   1                     1 = cycle and event counters advance
//  clear         in   1                     synchronous zero of live counters and sticky flags
//  event_inc     in   NUM_EVENTS            per-channel +1 strobe; honoured only while count_en=1
//  stat_control  in   1                     snapshot/report request; rising edge triggers
//  busy          out  1                     divider running; new requests are ignored
//  stat_valid    out  1                     1-cycle pulse when snapshot and IPC are ready
//  snap_cycles   out  CNT_W                 captured cycle count
//  snap_events   out  NUM_EVENTS*CNT_W      captured event counts; channel i at [i*CNT_W +: CNT_W]
//  ipc           out  CNT_W+FRAC_W          snap_events[0] * 2^FRAC_W / snap_cycles, truncated
//  div_zero      out  1                     snap_cycles was 0; ipc forced to all-ones
//  sat_flags     out  NUM_EVENTS+1          sticky saturation flags; bit NUM_EVENTS = cycle counter
// BEHAVIOUR
//  - Reset: every counter, snapshot, ipc, flag, busy and stat_valid is 0; FSM goes to IDLE.
//  - Live counters: +1 per posedge while count_en (events also need event_inc[i]).
//    Counters saturate at all-ones and never wrap; on saturation the matching
//    sat_flags bit sets and stays set until clear or rst.
//  - clear wins over a same-cycle increment. clear does not touch the snapshot,
//    ipc or the FSM.
//  - Edge detect: a registered copy of stat_control; trigger = stat_control & ~prev,
//    sampled at a posedge while in IDLE. A trigger outside IDLE is dropped; it is not queued.
//  - On the trigger edge T, the snapshot takes the live values present before that
//    edge's increment. FSM moves IDLE->DIV and busy=1 from T.
//  - DIV: restoring divider, one quotient bit per cycle, CNT_W+FRAC_W iterations.
//    Dividend = snap_events[0] << FRAC_W; divisor = snap_cycles (zero-extended).
//  - If snap_cycles==0, skip DIV (IDLE->DONE at T): ipc = all-ones, div_zero=1.
//    Otherwise div_zero=0.
//  - DONE: lasts one cycle with stat_valid=1 and busy=0, then returns to IDLE.
//    Latency is T+CNT_W+FRAC_W+1, or T+1 on divide-by-zero.
//  - ipc, div_zero and the snapshot hold until the next trigger. Live counting is
//    not paused by DIV/DONE.
//  - rst asserted mid-DIV aborts the divide; all outputs return to reset values at once.
//  - Sim only (`ifndef SYNTHESIS): in DONE, $display the cycles, each event and ipc;
//    ipc is printed as integer.fraction.
// STRUCTURE
//  - Package perf_stats_pkg: FSM state enum {IDLE, DIV, DONE} and a sat_inc function
//    that performs the saturating increment.
//  - Sub-module seq_udiv #(N=CNT_W+FRAC_W): start/busy/done restoring divider.
//    perf_stats_unit owns the counters, snapshot, edge detect and FSM.
//  - Counters are generated per channel with a generate loop over NUM_EVENTS.
// TESTING
//  1 rst mid-run: count 10 cycles, assert rst -> all outputs 0, no stat_valid,
//    FSM in IDLE.
//  2 Basic IPC (CNT_W=32, FRAC_W=8): 100 cycles with event_inc[0] on 50 of them,
//    then trigger -> snap_cycles=100, snap_events[0]=50, ipc=0x80 (0.5),
//    stat_valid exactly 41 cycles after the edge.
//  3 Divide by zero: trigger with count_en never set -> div_zero=1, ipc=all-ones,
//    stat_valid at T+1.
//  4 Saturation (CNT_W=4): 20 cycles with event_inc[1]=1 -> event 1 holds 15,
//    sat_flags[1]=1 and sat_flags[NUM_EVENTS]=1; clear -> counters 0, flags 0.
//  5 Retrigger while busy: second rising edge at T+5 -> ignored, exactly one
//    stat_valid pulse, result matches the first snapshot.
//  6 clear with event_inc in the same cycle -> counter reads 0 next cycle; the
//    snapshot taken earlier is unchanged.

Source files
------------

// File: rtl/perf_stats_pkg.sv
// perf_stats_pkg: shared FSM states and saturating-increment helper for perf_stats_unit
package perf_stats_pkg;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] m;
    m = (w >= MAX_W) ? '1 : (MAX_W'(1) << w) - MAX_W'(1);
    return (v >= m) ? m : v + MAX_W'(1);
  endfunction
endpackage

// File: rtl/perf_stats_unit_seq_udiv.sv
// seq_udiv: restoring unsigned divider, one quotient bit per cycle, N cycles per divide
module seq_udiv #(
  parameter int N = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] r, q, d, r_in, q_in, d_in, r_nx;
  logic [N:0] t, diff;
  logic [CW-1:0] cnt;
  logic ld, ge;
  assign ld = start & ~busy;
  assign r_in = ld ? '0 : r;
  assign q_in = ld ? dividend : q;
  assign d_in = ld ? divisor : d;
  assign t = {r_in, q_in[N-1]};
  assign diff = t - {1'b0, d_in};
  assign ge = t >= {1'b0, d_in};
  assign r_nx = ge ? diff[N-1:0] : t[N-1:0];
  assign quotient = q;
  // the load cycle also performs the first iteration so the result is ready N cycles after start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        r <= r_nx;
        q <= {q_in[N-2:0], ge};
        d <= divisor;
        cnt <= CW'(N - 1);
        busy <= 1'b1;
      end else if (busy) begin
        r <= r_nx;
        q <= {q_in[N-2:0], ge};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/perf_stats_unit.sv
// perf_stats_unit: saturating cycle/event counters, edge-triggered snapshot and fixed-point IPC
module perf_stats_unit
  import perf_stats_pkg::*;
#(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 32,
  parameter int FRAC_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         count_en,
  input  logic                         clear,
  input  logic [NUM_EVENTS-1:0]        event_inc,
  input  logic                         stat_control,
  output logic                         busy,
  output logic                         stat_valid,
  output logic [CNT_W-1:0]             snap_cycles,
  output logic [NUM_EVENTS*CNT_W-1:0]  snap_events,
  output logic [CNT_W+FRAC_W-1:0]      ipc,
  output logic                         div_zero,
  output logic [NUM_EVENTS:0]          sat_flags
);
  localparam int N = CNT_W + FRAC_W;
  localparam logic [CNT_W-1:0] MAXV = '1;
  state_t state;
  logic [(NUM_EVENTS+1)*CNT_W-1:0] live;
  logic [NUM_EVENTS:0] inc;
  logic [CNT_W-1:0] live_cyc;
  logic [N-1:0] quot;
  logic prev, trig, div_start, div_busy, div_done;
  // the top counter slot is the cycle counter, which advances on every enabled cycle
  assign inc = {1'b1, event_inc} & {(NUM_EVENTS+1){count_en}};
  assign live_cyc = live[NUM_EVENTS*CNT_W +: CNT_W];
  assign trig = stat_control & ~prev;
  assign div_start = (state == IDLE) && trig && (live_cyc != '0) && !div_busy;
  genvar g;
  generate
    for (g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
      logic [CNT_W-1:0] c;
      logic f;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          c <= '0;
          f <= 1'b0;
        end else if (clear) begin
          c <= '0;
          f <= 1'b0;
        end else if (inc[g]) begin
          c <= CNT_W'(sat_inc(MAX_W'(c), CNT_W));
          f <= f | (c >= MAXV - 1'b1);
        end
      assign live[g*CNT_W +: CNT_W] = c;
      assign sat_flags[g] = f;
    end
  endgenerate
  seq_udiv #(.N(N)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({live[CNT_W-1:0], {FRAC_W{1'b0}}}),
    .divisor  (N'(live_cyc)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quot)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      prev <= 1'b0;
      busy <= 1'b0;
      stat_valid <= 1'b0;
      snap_cycles <= '0;
      snap_events <= '0;
      ipc <= '0;
      div_zero <= 1'b0;
    end else begin
      prev <= stat_control;
      stat_valid <= 1'b0;
      case (state)
        IDLE: if (trig) begin
          snap_cycles <= live_cyc;
          snap_events <= live[NUM_EVENTS*CNT_W-1:0];
          if (live_cyc == '0) begin
            ipc <= '1;
            div_zero <= 1'b1;
            stat_valid <= 1'b1;
            state <= DONE;
          end else begin
            div_zero <= 1'b0;
            busy <= 1'b1;
            state <= DIV;
          end
        end
        DIV: if (div_done) begin
          ipc <= quot;
          busy <= 1'b0;
          stat_valid <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && state == DONE) begin
      $display("perf_stats: cycles=%0d", snap_cycles);
      for (int i = 0; i < NUM_EVENTS; i++)
        $display("perf_stats: event[%0d]=%0d", i, snap_events[i*CNT_W +: CNT_W]);
      $display("perf_stats: ipc=%0d.%03d", ipc >> FRAC_W, (64'(ipc[FRAC_W-1:0]) * 64'd1000) >> FRAC_W);
    end
`endif
endmodule

// File: tb/tb_perf_stats_unit.sv
// tb_perf_stats_unit: table vectors, corner sequences and randomized runs against a counting model
module tb_perf_stats_unit;
  localparam int NE = 4, CW = 32, FW = 8, N = CW + FW;
  localparam logic [N-1:0] ONES = '1;
  logic clk = 0, rst = 1, count_en = 0, clear = 0, stat_control = 0;
  logic [NE-1:0] event_inc = '0;
  logic busy, stat_valid, div_zero;
  logic [CW-1:0] snap_cycles;
  logic [NE*CW-1:0] snap_events;
  logic [N-1:0] ipc;
  logic [NE:0] sat_flags;
  logic s_busy, s_valid, s_dz;
  logic [3:0] s_cyc;
  logic [NE*4-1:0] s_ev;
  logic [11:0] s_ipc;
  logic [NE:0] s_sat;
  int pass_n = 0, total_n = 0;
  longint m_cyc;
  longint m_ev[NE];

  perf_stats_unit #(.NUM_EVENTS(NE), .CNT_W(CW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst), .count_en(count_en), .clear(clear), .event_inc(event_inc),
    .stat_control(stat_control), .busy(busy), .stat_valid(stat_valid), .snap_cycles(snap_cycles),
    .snap_events(snap_events), .ipc(ipc), .div_zero(div_zero), .sat_flags(sat_flags));
  perf_stats_unit #(.NUM_EVENTS(NE), .CNT_W(4), .FRAC_W(FW)) dut_s (
    .clk(clk), .rst(rst), .count_en(count_en), .clear(clear), .event_inc(event_inc),
    .stat_control(stat_control), .busy(s_busy), .stat_valid(s_valid), .snap_cycles(s_cyc),
    .snap_events(s_ev), .ipc(s_ipc), .div_zero(s_dz), .sat_flags(s_sat));

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ev0;
    logic [N-1:0] ipc;
    int lat;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    if (rst || clear) begin
      m_cyc = 0;
      foreach (m_ev[i]) m_ev[i] = 0;
    end else if (count_en) begin
      m_cyc++;
      foreach (m_ev[i]) if (event_inc[i]) m_ev[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  // raise stat_control for one edge, then count edges until stat_valid is seen
  task automatic measure(output int lat, output logic bz);
    stat_control = 1;
    tick();
    stat_control = 0;
    bz = busy;
    lat = 0;
    for (int j = 0; j < 100 && lat == 0; j++) begin
      if (stat_valid) lat = j + 1;
      else tick();
    end
    if (lat != 0) begin
      tick();
      chk("valid one cycle", stat_valid, 0);
    end
  endtask

  task automatic model_report(input string tag);
    longint ec, eipc;
    longint ee[NE];
    int lat;
    logic bz;
    ec = m_cyc;
    foreach (ee[i]) ee[i] = m_ev[i];
    eipc = (ec == 0) ? longint'(ONES) : (ee[0] << FW) / ec;
    measure(lat, bz);
    chk({tag, " latency"}, lat, ec == 0 ? 1 : N + 1);
    chk({tag, " busy at T"}, bz, ec != 0);
    chk({tag, " snap_cycles"}, snap_cycles, ec);
    for (int i = 0; i < NE; i++) chk($sformatf("%s ev%0d", tag, i), snap_events[i*CW +: CW], ee[i]);
    chk({tag, " ipc"}, ipc, eipc);
    chk({tag, " div_zero"}, div_zero, ec == 0);
  endtask

  initial begin
    int lat, pulses, first;
    logic bz;
    logic [CW-1:0] k_cyc;
    logic [NE*CW-1:0] k_ev;
    logic [N-1:0] k_ipc;
    tbl[0] = '{100, 50, 40'h80, 41};
    tbl[1] = '{0, 0, ONES, 1};
    tbl[2] = '{10, 10, 40'h100, 41};
    tbl[3] = '{3, 1, 40'h55, 41};
    tbl[4] = '{7, 2, 40'h49, 41};
    tick();
    tick();
    rst = 0;
    chk("reset busy", busy, 0);
    chk("reset valid", stat_valid, 0);
    chk("reset ipc", ipc, 0);
    chk("reset sat", sat_flags, 0);

    // rst during a divide
    count_en = 1;
    repeat (10) tick();
    count_en = 0;
    stat_control = 1;
    tick();
    stat_control = 0;
    repeat (4) tick();
    chk("pre-rst busy", busy, 1);
    rst = 1;
    #1;
    chk("rst busy", busy, 0);
    chk("rst valid", stat_valid, 0);
    chk("rst snap_cycles", snap_cycles, 0);
    chk("rst snap_events", snap_events == '0, 1);
    chk("rst ipc", ipc, 0);
    chk("rst div_zero", div_zero, 0);
    tick();
    tick();
    rst = 0;
    pulses = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (stat_valid) pulses++;
    end
    chk("no valid after rst", pulses, 0);
    chk("idle after rst", busy, 0);

    // table vectors
    foreach (tbl[v]) begin
      clear = 1;
      tick();
      clear = 0;
      count_en = 1;
      for (int k = 0; k < tbl[v].cyc; k++) begin
        event_inc[0] = (k < tbl[v].ev0);
        tick();
      end
      count_en = 0;
      event_inc = '0;
      measure(lat, bz);
      chk($sformatf("tbl%0d latency", v), lat, tbl[v].lat);
      chk($sformatf("tbl%0d cycles", v), snap_cycles, tbl[v].cyc);
      chk($sformatf("tbl%0d ev0", v), snap_events[CW-1:0], tbl[v].ev0);
      chk($sformatf("tbl%0d ipc", v), ipc, tbl[v].ipc);
      chk($sformatf("tbl%0d div_zero", v), div_zero, tbl[v].cyc == 0);
    end

    // saturation on the 4-bit instance
    clear = 1;
    tick();
    clear = 0;
    count_en = 1;
    event_inc = 4'b0010;
    repeat (20) tick();
    count_en = 0;
    event_inc = '0;
    measure(lat, bz);
    chk("sat ev1", s_ev[7:4], 15);
    chk("sat cycles", s_cyc, 15);
    chk("sat flags", s_sat, 5'b10010);
    chk("wide ev1", snap_events[2*CW-1:CW], 20);
    chk("wide sat none", sat_flags, 0);
    clear = 1;
    tick();
    clear = 0;
    chk("sat flags cleared", s_sat, 0);
    measure(lat, bz);
    chk("sat cleared cycles", s_cyc, 0);
    chk("sat cleared ev1", s_ev[7:4], 0);
    chk("sat cleared dz", s_dz, 1);
    chk("sat cleared ipc", s_ipc, 12'hFFF);

    // retrigger while busy is dropped
    clear = 1;
    tick();
    clear = 0;
    count_en = 1;
    for (int k = 0; k < 30; k++) begin
      event_inc = NE'(k % 3 == 0 ? 4'b0101 : 4'b0010);
      tick();
    end
    count_en = 0;
    event_inc = '0;
    k_cyc = CW'(m_cyc);
    k_ev = '0;
    for (int i = 0; i < NE; i++) k_ev[i*CW +: CW] = CW'(m_ev[i]);
    k_ipc = N'((m_ev[0] << FW) / m_cyc);
    stat_control = 1;
    tick();
    stat_control = 0;
    count_en = 1;
    repeat (3) tick();
    stat_control = 1;
    tick();
    stat_control = 0;
    count_en = 0;
    pulses = 0;
    first = 0;
    for (int j = 5; j < 100; j++) begin
      if (stat_valid) begin
        pulses++;
        if (first == 0) first = j;
      end
      tick();
    end
    chk("retrig pulses", pulses, 1);
    chk("retrig latency", first, N + 1);
    chk("retrig cycles", snap_cycles, k_cyc);
    chk("retrig events", snap_events == k_ev, 1);
    chk("retrig ipc", ipc, k_ipc);

    // clear racing an increment; the held snapshot is untouched
    clear = 1;
    count_en = 1;
    event_inc = '1;
    tick();
    clear = 0;
    count_en = 0;
    event_inc = '0;
    chk("clear keeps snap", snap_events == k_ev, 1);
    chk("clear keeps ipc", ipc, k_ipc);
    model_report("clear race");

    // randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(1, 50);
      for (int k = 0; k < len; k++) begin
        count_en = ($urandom_range(0, 3) != 0);
        event_inc = NE'($urandom);
        clear = ($urandom_range(0, 15) == 0);
        tick();
      end
      clear = 0;
      model_report($sformatf("rnd%0d", r));
    end
    chk("rnd wide sat none", sat_flags, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
